// File: rtl/rtc_count_sync.sv
// PCLK-domain reader for the Gray-coded RTC count: synchronise, stability-filter, convert, publish.
// Optional macro RTC_COUNT_SYNC_HOLD_EN adds UpdateBusy to stall publication while the consumer is busy.
module rtc_count_sync #(
    parameter int WIDTH         = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 2
) (
    input  logic             PCLK,
    input  logic             POR,
    input  logic [WIDTH-1:0] CountGray,
    input  logic             ClrErr,
`ifdef RTC_COUNT_SYNC_HOLD_EN
    input  logic             UpdateBusy,
`endif
    output logic [WIDTH-1:0] CountSync,
    output logic             CountEdge,
    output logic             CountErr
);

    localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;

    typedef enum logic [1:0] {ST_WAIT, ST_STABLE, ST_CHECK} state_e;

    state_e                            state_q, state_d;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  cand_gray_q, cand_gray_d;
    logic [WIDTH-1:0]                  accept_gray_q, accept_gray_d;
    logic [CNT_W-1:0]                  stable_cnt_q, stable_cnt_d;
    logic [WIDTH-1:0]                  count_sync_q, count_sync_d;
    logic                              count_edge_q, count_edge_d;
    logic                              count_err_q, count_err_d;
    logic [WIDTH-1:0]                  sync_gray;
    logic [WIDTH-1:0]                  cand_bin;
    logic                              hold;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

`ifdef RTC_COUNT_SYNC_HOLD_EN
    assign hold = UpdateBusy;
`else
    assign hold = 1'b0;
`endif

    assign sync_gray = sync_q[SYNC_STAGES-1];
    assign cand_bin  = gray2bin(cand_gray_q);

    always_ff @(posedge PCLK or posedge POR) begin
        if (POR) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], CountGray};
    end

    always_ff @(posedge PCLK or posedge POR) begin
        if (POR) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:   if (sync_gray != accept_gray_q) state_d = ST_STABLE;
            ST_STABLE: begin
                if (sync_gray == accept_gray_q)
                    state_d = ST_WAIT;
                else if (sync_gray == cand_gray_q &&
                         stable_cnt_q == CNT_W'(STABLE_CYCLES - 1))
                    state_d = ST_CHECK;
            end
            ST_CHECK:  if (!hold) state_d = ST_WAIT;
            default:   state_d = ST_WAIT;
        endcase
    end

    // Set wins over ClrErr: the clear is the default, the ST_CHECK set overrides it.
    always_comb begin
        cand_gray_d   = cand_gray_q;
        stable_cnt_d  = stable_cnt_q;
        accept_gray_d = accept_gray_q;
        count_sync_d  = count_sync_q;
        count_edge_d  = 1'b0;
        count_err_d   = count_err_q & ~ClrErr;
        case (state_q)
            ST_WAIT: begin
                if (sync_gray != accept_gray_q) begin
                    cand_gray_d  = sync_gray;
                    stable_cnt_d = CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (sync_gray != accept_gray_q) begin
                    if (sync_gray != cand_gray_q) begin
                        cand_gray_d  = sync_gray;
                        stable_cnt_d = CNT_W'(1);
                    end else if (stable_cnt_q != CNT_W'(STABLE_CYCLES - 1)) begin
                        stable_cnt_d = stable_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_CHECK: begin
                if (!hold) begin
                    count_sync_d  = cand_bin;
                    accept_gray_d = cand_gray_q;
                    count_edge_d  = 1'b1;
                    if (cand_bin != count_sync_q + WIDTH'(1)) count_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK or posedge POR) begin
        if (POR) begin
            cand_gray_q   <= '0;
            stable_cnt_q  <= '0;
            accept_gray_q <= '0;
            count_sync_q  <= '0;
            count_edge_q  <= 1'b0;
            count_err_q   <= 1'b0;
        end else begin
            cand_gray_q   <= cand_gray_d;
            stable_cnt_q  <= stable_cnt_d;
            accept_gray_q <= accept_gray_d;
            count_sync_q  <= count_sync_d;
            count_edge_q  <= count_edge_d;
            count_err_q   <= count_err_d;
        end
    end

    assign CountSync = count_sync_q;
    assign CountEdge = count_edge_q;
    assign CountErr  = count_err_q;

endmodule

// File: tb/tb_rtc_count_sync.sv
// Bench for rtc_count_sync: directed steps plus random count transfers checked against an
// arithmetic model of the accepted count, sticky error flag and edge timing.
module tb_rtc_count_sync;

    logic        PCLK = 1'b0;
    logic        POR  = 1'b1;
    logic [31:0] CountGray = '0;
    logic        ClrErr = 1'b0;
    logic        UpdateBusy = 1'b0;
    logic [31:0] CountSync;
    logic        CountEdge;
    logic        CountErr;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] m_sync = '0;
    logic        m_err  = 1'b0;

    always #5 PCLK = ~PCLK;

    rtc_count_sync dut (
        .PCLK      (PCLK),
        .POR       (POR),
        .CountGray (CountGray),
        .ClrErr    (ClrErr),
`ifdef RTC_COUNT_SYNC_HOLD_EN
        .UpdateBusy(UpdateBusy),
`endif
        .CountSync (CountSync),
        .CountEdge (CountEdge),
        .CountErr  (CountErr)
    );

    function automatic logic [31:0] b2g(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] g2b(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int s = 1; s < 32; s = s * 2) b = b ^ (b >> s);
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive optional glitch value gl for gl_cyc cycles, then hold g; watch 16 edges.
    task automatic xfer(input logic [31:0] gl, input int gl_cyc, input logic [31:0] g,
                        input bit clr);
        int          pulses;
        int          first;
        bit          exp_pulse;
        bit          set;
        logic [31:0] nb;
        pulses = 0;
        first  = 0;
        @(posedge PCLK); #1;
        ClrErr = clr;
        if (gl_cyc > 0) begin
            CountGray = gl;
            repeat (gl_cyc) @(posedge PCLK);
            #1;
        end
        CountGray = g;
        for (int i = gl_cyc + 1; i <= 16; i++) begin
            @(posedge PCLK); #1;
            if (CountEdge) begin
                pulses++;
                if (first == 0) first = i;
                ClrErr = 1'b0;
            end
        end
        ClrErr = 1'b0;
        exp_pulse = (g != b2g(m_sync));
        nb        = g2b(g);
        set       = exp_pulse && (nb != m_sync + 32'd1);
        if (exp_pulse) m_sync = nb;
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        chk("edge_pulses", 32'(pulses), exp_pulse ? 32'd1 : 32'd0);
        chk("count_sync", CountSync, m_sync);
        chk("count_err", {31'd0, CountErr}, {31'd0, m_err});
        if (gl_cyc == 0 && exp_pulse) chk("edge_latency", 32'(first), 32'd5);
    endtask

    initial begin
        int          r;
        int          pulses;
        int          first;
        logic [31:0] g;

        #2;
        chk("reset_sync", CountSync, 32'd0);
        chk("reset_edge", {31'd0, CountEdge}, 32'd0);
        chk("reset_err", {31'd0, CountErr}, 32'd0);
        @(posedge PCLK); #1;
        POR = 1'b0;

        // Clean 0 -> 1 then count up to 5
        xfer('0, 0, 32'h1, 1'b0);
        xfer('0, 0, 32'h3, 1'b0);
        xfer('0, 0, 32'h2, 1'b0);
        xfer('0, 0, 32'h6, 1'b0);
        xfer('0, 0, 32'h7, 1'b0);

        // 5 -> 6 good, 6 -> 9 error, then clear
        xfer('0, 0, 32'h5, 1'b0);
        xfer('0, 0, 32'hD, 1'b0);
        chk("err_after_jump", {31'd0, CountErr}, 32'd1);
        @(posedge PCLK); #1;
        ClrErr = 1'b1;
        @(posedge PCLK); #1;
        ClrErr = 1'b0;
        m_err  = 1'b0;
        chk("err_cleared", {31'd0, CountErr}, 32'd0);

        // Back to 5 by a jump (error), clear, then glitch cases
        xfer('0, 0, 32'h7, 1'b1);
        xfer(32'h5, 1, 32'h7, 1'b0);
        xfer(32'h5, 1, 32'hD, 1'b0);

        // Clear coinciding with an error set: set wins
        xfer('0, 0, 32'h7, 1'b1);

        // Wrap FFFFFFFF -> 0
        xfer('0, 0, 32'h8000_0000, 1'b0);
        xfer('0, 0, 32'h8000_0000, 1'b1);
        xfer('0, 0, 32'h0000_0000, 1'b0);
        chk("wrap_err", {31'd0, CountErr}, 32'd0);

        // Random transfers
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            case (r)
                6:       xfer('0, 0, $urandom, $urandom_range(0, 3) == 0);
                7:       xfer('0, 0, b2g(m_sync), 1'b1);
                8:       xfer($urandom, 1, b2g(m_sync + 32'd1), 1'b0);
                9:       xfer(b2g(m_sync + 32'd1), 1, b2g(m_sync), 1'b0);
                default: xfer('0, 0, b2g(m_sync + 32'd1), $urandom_range(0, 3) == 0);
            endcase
        end

        // Reset during ST_STABLE with a candidate pending
        xfer('0, 0, b2g(32'h1234), 1'b0);
        @(posedge PCLK); #1;
        CountGray = b2g(32'h1235);
        repeat (3) @(posedge PCLK);
        #2;
        POR = 1'b1;
        #1;
        chk("por_sync", CountSync, 32'd0);
        chk("por_edge", {31'd0, CountEdge}, 32'd0);
        chk("por_err", {31'd0, CountErr}, 32'd0);
        CountGray = '0;
        m_sync    = '0;
        m_err     = 1'b0;
        @(posedge PCLK); #1;
        POR    = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge PCLK); #1;
            if (CountEdge) pulses++;
        end
        chk("por_no_edge", 32'(pulses), 32'd0);
        chk("por_sync_after", CountSync, 32'd0);
        xfer('0, 0, 32'h1, 1'b0);

`ifdef RTC_COUNT_SYNC_HOLD_EN
        // Publication held off by UpdateBusy
        g      = b2g(m_sync + 32'd1);
        pulses = 0;
        first  = 0;
        @(posedge PCLK); #1;
        CountGray = g;
        for (int i = 1; i <= 16; i++) begin
            @(posedge PCLK); #1;
            if (CountEdge) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (i == 3) UpdateBusy = 1'b1;
            if (i == 7) UpdateBusy = 1'b0;
        end
        m_sync = m_sync + 32'd1;
        chk("hold_pulses", 32'(pulses), 32'd1);
        chk("hold_latency", 32'(first), 32'd8);
        chk("hold_sync", CountSync, m_sync);
`else
        g = '0;
        first = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
